rotor_step_controller: RTL and testbench
========================================

Name: rotor_step_controller

Overview:
- Sequences the three-rotor Enigma stack (left, middle, right), each holding a position 0–25.
- Per accepted keypress, applies Enigma stepping rules (turnover notches, optional double-step) exactly once.
- Holds off the next key until the cipher path through the rotors has settled, then pulses step_done.
- Also loads rotor start positions from switches; sits between the key-input logic and the rotor/cipher datapath.

Parameters:
- NOTCH_R, 21, right-rotor position at which the middle rotor is carried (V).
- NOTCH_M, 4, middle-rotor position at which the left rotor is carried (E).
- SETTLE_CYCLES, 2, wait cycles after a position update before step_done; legal range 0–15.

Ports:
- clk  input  1  system clock (divided clock from the rate divider)
- resetn  input  1  asynchronous active-low reset
- load  input  1  sync request to load init positions; honoured only in IDLE
- init_l  input  5  left start position
- init_m  input  5  middle start position
- init_r  input  5  right start position
- key_valid  input  1  keypress request
- key_ready  output  1  high when a keypress can be accepted
- pos_l  output  5  left rotor position, 0–25
- pos_m  output  5  middle rotor position, 0–25
- pos_r  output  5  right rotor position, 0–25
- busy  output  1  high in STEP/SETTLE/DONE
- step_done  output  1  one-cycle pulse: positions stable, cipher output valid
- load_err  output  1  one-cycle pulse: an init value >25 was loaded as 0

Behaviour:
- Reset (async, resetn=0):
  - pos_l/m/r=0, state=IDLE, key_ready=1.
  - busy=0, step_done=0, load_err=0, settle counter=0.
  - Reset mid-operation aborts the step immediately; no partial update survives.
- States: IDLE, STEP, SETTLE, DONE. Registered outputs only.
- IDLE:
  - key_ready=1.
  - If load=1: each pos_x<=init_x if init_x<=25, else 0. load_err pulses next cycle if any init_x>25. Stay IDLE.
  - load has priority over key_valid in the same cycle; the key is not accepted and key_ready stays 1.
  - Else if key_valid=1: go to STEP; key_ready=0 from the next cycle.
- STEP (exactly one cycle): all rotors update together, computed from pre-step values.
  - Right always steps.
  - Middle steps if pos_r==NOTCH_R, or (DOUBLE_STEP_EN) pos_m==NOTCH_M.
  - Left steps if pos_m==NOTCH_M; without DOUBLE_STEP_EN it also requires pos_r==NOTCH_R.
  - Increment is modulo 26: 25 -> 0.
  - Next state: SETTLE with counter=SETTLE_CYCLES-1, or DONE directly if SETTLE_CYCLES=0.
- SETTLE: decrements the counter; goes to DONE when the counter is 0. Occupies exactly SETTLE_CYCLES cycles.
- DONE (one cycle): step_done=1, then IDLE; key_ready=1 again from the cycle after DONE.
- Latency: key accepted at edge T0.
  - New positions are visible after T0+1.
  - step_done is high in the cycle after edge T0+1+SETTLE_CYCLES.
  - Next key can be accepted at edge T0+3+SETTLE_CYCLES.
- Ignored inputs:
  - key_valid outside IDLE is ignored, not queued; the requester must hold it until it sees key_ready.
  - load outside IDLE is ignored.
- Positions never hold a value above 25.

Optional Feature:
- Macro: ROTOR_DOUBLE_STEP_EN.
- Defined: historical double-step anomaly. A middle rotor sitting at NOTCH_M steps itself and carries the left rotor on the next key, regardless of the right rotor.
- Undefined: pure odometer. Middle steps only when the right rotor is at NOTCH_R. Left steps only when pos_m==NOTCH_M and pos_r==NOTCH_R at the same time.

Test Plan:
- Reset with resetn=0 mid-SETTLE -> all positions 0, key_ready=1, busy=0 immediately (asynchronous), with no clock edge required.
- From (0,0,0), one key, SETTLE_CYCLES=2 -> positions (0,0,1) one cycle after acceptance; step_done pulses exactly 3 cycles after acceptance; key_ready low for 4 cycles.
- Load (3,7,25), then a key -> (3,7,0). Load init_r=30 -> pos_r=0 and load_err pulses once.
- Load and key_valid both asserted in IDLE -> init loaded, no step, no step_done.
- ROTOR_DOUBLE_STEP_EN defined, start (0,3,20), four keys -> (0,3,21), (0,4,22), (1,5,23), (1,5,24).
- Macro undefined, same start and four keys -> (0,3,21), (0,4,22), (0,4,23), (0,4,24).

Source files
------------

// File: rtl/rotor_step_controller.sv
// Three-rotor Enigma stepping sequencer: one step per accepted key, then a settle wait and step_done.
// Define ROTOR_DOUBLE_STEP_EN for the historical middle-rotor double-step; default is a pure odometer.
module rotor_step_controller #(
  parameter int unsigned NOTCH_R       = 21,
  parameter int unsigned NOTCH_M       = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [4:0] init_l,
  input  logic [4:0] init_m,
  input  logic [4:0] init_r,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r,
  output logic       busy,
  output logic       step_done,
  output logic       load_err
);

  localparam logic [4:0] NotchR     = 5'(NOTCH_R);
  localparam logic [4:0] NotchM     = 5'(NOTCH_M);
  localparam logic [3:0] SettleInit = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStep, StSettle, StDone} state_e;

  state_e     state_q, state_d;
  logic [4:0] pos_l_q, pos_l_d;
  logic [4:0] pos_m_q, pos_m_d;
  logic [4:0] pos_r_q, pos_r_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_err_d;
  logic       step_m, step_l;
  logic       key_ready_q, busy_q, step_done_q, load_err_q;

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  // Out-of-range init values load as 0 rather than being clipped or wrapped.
  function automatic logic [4:0] clamp26(input logic [4:0] v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  always_comb begin
    step_m = 1'b0;
    step_l = 1'b0;
`ifdef ROTOR_DOUBLE_STEP_EN
    step_m = (pos_r_q == NotchR) || (pos_m_q == NotchM);
    step_l = (pos_m_q == NotchM);
`else
    step_m = (pos_r_q == NotchR);
    step_l = (pos_m_q == NotchM) && (pos_r_q == NotchR);
`endif
  end

  always_comb begin
    state_d    = state_q;
    pos_l_d    = pos_l_q;
    pos_m_d    = pos_m_q;
    pos_r_d    = pos_r_q;
    cnt_d      = cnt_q;
    load_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          pos_l_d    = clamp26(init_l);
          pos_m_d    = clamp26(init_m);
          pos_r_d    = clamp26(init_r);
          load_err_d = (init_l > 5'd25) || (init_m > 5'd25) || (init_r > 5'd25);
        end else if (key_valid) begin
          state_d = StStep;
        end
      end
      StStep: begin
        pos_r_d = inc26(pos_r_q);
        if (step_m) pos_m_d = inc26(pos_m_q);
        if (step_l) pos_l_d = inc26(pos_l_q);
        cnt_d   = SettleInit;
        state_d = (SETTLE_CYCLES == 0) ? StDone : StSettle;
      end
      StSettle: begin
        if (cnt_q == 4'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      pos_l_q     <= 5'd0;
      pos_m_q     <= 5'd0;
      pos_r_q     <= 5'd0;
      cnt_q       <= 4'd0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      step_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_l_q     <= pos_l_d;
      pos_m_q     <= pos_m_d;
      pos_r_q     <= pos_r_d;
      cnt_q       <= cnt_d;
      key_ready_q <= (state_d == StIdle);
      busy_q      <= (state_d != StIdle);
      step_done_q <= (state_d == StDone);
      load_err_q  <= load_err_d;
    end
  end

  assign key_ready = key_ready_q;
  assign busy      = busy_q;
  assign step_done = step_done_q;
  assign load_err  = load_err_q;
  assign pos_l     = pos_l_q;
  assign pos_m     = pos_m_q;
  assign pos_r     = pos_r_q;

endmodule

// File: tb/tb_rotor_step_controller.sv
// Directed bench for rotor_step_controller (default parameters, SETTLE_CYCLES=2).
// Expected double-step results follow ROTOR_DOUBLE_STEP_EN as defined for the build.
module tb_rotor_step_controller;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       load = 1'b0;
  logic [4:0] init_l = '0, init_m = '0, init_r = '0;
  logic       key_valid = 1'b0;
  logic       key_ready, busy, step_done, load_err;
  logic [4:0] pos_l, pos_m, pos_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rotor_step_controller dut (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .init_l    (init_l),
    .init_m    (init_m),
    .init_r    (init_r),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .pos_l     (pos_l),
    .pos_m     (pos_m),
    .pos_r     (pos_r),
    .busy      (busy),
    .step_done (step_done),
    .load_err  (load_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int l, input int m, input int r);
    check_eq({tag, ".l"}, 32'(pos_l), 32'(l));
    check_eq({tag, ".m"}, 32'(pos_m), 32'(m));
    check_eq({tag, ".r"}, 32'(pos_r), 32'(r));
  endtask

  task automatic do_load(input int l, input int m, input int r);
    @(negedge clk);
    load = 1'b1; init_l = 5'(l); init_m = 5'(m); init_r = 5'(r);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Press one key, wait (bounded) for step_done, then check positions and return to IDLE.
  task automatic key_and_check(input string tag, input int l, input int m, input int r);
    int waited = 0;
    @(negedge clk);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    while (!step_done && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, ".done_seen"}, 32'(step_done), 32'd1);
    check_pos(tag, l, m, r);
    @(negedge clk);
    check_eq({tag, ".ready"}, 32'(key_ready), 32'd1);
  endtask

  initial begin
    #12;
    check_pos("rst", 0, 0, 0);
    check_eq("rst.ready", 32'(key_ready), 32'd1);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(step_done), 32'd0);
    check_eq("rst.lerr", 32'(load_err), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Single key latency from (0,0,0).
    @(negedge clk);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check_eq("lat1.ready", 32'(key_ready), 32'd0);
    check_eq("lat1.busy", 32'(busy), 32'd1);
    check_pos("lat1", 0, 0, 0);
    @(negedge clk);
    check_pos("lat2", 0, 0, 1);
    check_eq("lat2.done", 32'(step_done), 32'd0);
    check_eq("lat2.ready", 32'(key_ready), 32'd0);
    @(negedge clk);
    check_eq("lat3.done", 32'(step_done), 32'd0);
    check_eq("lat3.ready", 32'(key_ready), 32'd0);
    @(negedge clk);
    check_eq("lat4.done", 32'(step_done), 32'd1);
    check_eq("lat4.ready", 32'(key_ready), 32'd0);
    @(negedge clk);
    check_eq("lat5.done", 32'(step_done), 32'd0);
    check_eq("lat5.ready", 32'(key_ready), 32'd1);
    check_eq("lat5.busy", 32'(busy), 32'd0);

    // Load and right-rotor wrap.
    do_load(3, 7, 25);
    check_pos("ld", 3, 7, 25);
    check_eq("ld.lerr", 32'(load_err), 32'd0);
    key_and_check("wrap", 3, 7, 0);

    // Out-of-range init.
    do_load(1, 2, 30);
    check_pos("ldbad", 1, 2, 0);
    check_eq("ldbad.lerr", 32'(load_err), 32'd1);
    @(negedge clk);
    check_eq("ldbad.lerr_off", 32'(load_err), 32'd0);

    // load wins over key_valid.
    @(negedge clk);
    load = 1'b1; key_valid = 1'b1; init_l = 5'd5; init_m = 5'd6; init_r = 5'd7;
    @(negedge clk);
    load = 1'b0; key_valid = 1'b0;
    check_pos("prio", 5, 6, 7);
    check_eq("prio.ready", 32'(key_ready), 32'd1);
    check_eq("prio.busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("prio.nodone", 32'(step_done), 32'd0);
      check_pos("prio.hold", 5, 6, 7);
    end

    // Asynchronous reset mid-SETTLE.
    @(negedge clk);
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    check_pos("pre_arst", 5, 6, 8);
    check_eq("pre_arst.busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_pos("arst", 0, 0, 0);
    check_eq("arst.ready", 32'(key_ready), 32'd1);
    check_eq("arst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("arst.nodone", 32'(step_done), 32'd0);
    check_pos("arst.hold", 0, 0, 0);

    // Notch sequence from (0,3,20).
    do_load(0, 3, 20);
    key_and_check("k1", 0, 3, 21);
    key_and_check("k2", 0, 4, 22);
`ifdef ROTOR_DOUBLE_STEP_EN
    key_and_check("k3", 1, 5, 23);
    key_and_check("k4", 1, 5, 24);
`else
    key_and_check("k3", 0, 4, 23);
    key_and_check("k4", 0, 4, 24);
`endif

    // Odometer carry into left rotor: (2,4,21) -> (3,5,22) in both modes.
    do_load(2, 4, 21);
    key_and_check("carry", 3, 5, 22);
    // Middle wrap at 25 with right carry.
    do_load(9, 25, 21);
    key_and_check("mwrap", 9, 0, 22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
